// File: rtl/spectrum_bands_if.sv
// Band-level output stream toward the LED pattern logic.
// The block drives it through the master modport, the LED side uses slave.
interface spectrum_bands_if #(
  parameter int IDX_W = 3
);
  logic [23:0]      band_level;
  logic [IDX_W-1:0] band_index;
  logic             band_valid;
  logic             band_ready;

  modport master (output band_level, band_index, band_valid, input band_ready);
  modport slave  (input band_level, band_index, band_valid, output band_ready);
endinterface

// File: rtl/spectrum_bands.sv
// Reduces 128-bin FFT magnitude frames to NUM_BANDS peak-hold/decay levels
// and streams each completed frame out one band per accepted cycle.
module spectrum_bands_lane #(
  parameter int ACC_W       = 27,
  parameter int LOG_BPB     = 3,
  parameter int DECAY_SHIFT = 4
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic        acc_clr,
  input  logic        acc_add,
  input  logic [23:0] mag,
  input  logic        lvl_upd,
  output logic [23:0] level
);
  logic [ACC_W-1:0] acc, acc_sum;
  logic [23:0]      avg;

  // The closing bin of a frame lands in the same cycle as the level update,
  // so the average is taken from the post-add sum.
  assign acc_sum = acc + (acc_add ? ACC_W'(mag) : '0);
  assign avg     = 24'(acc_sum >> LOG_BPB);

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      level <= '0;
    end else begin
      if (acc_clr)      acc <= '0;
      else if (acc_add) acc <= acc_sum;
      if (lvl_upd)
        level <= (avg >= level) ? avg : level - (level >> DECAY_SHIFT);
    end
  end
endmodule

module spectrum_bands #(
  parameter int NUM_BANDS     = 8,
  parameter int BINS_PER_BAND = 8,
  parameter int DECAY_SHIFT   = 4
) (
  input  logic              clk_100mhz,
  input  logic              rst_n,
  input  logic [23:0]       freq_mag,
  input  logic [6:0]        freq_index,
  input  logic              mag_valid,
  spectrum_bands_if.master  bnd,
  output logic              sync_err,
  output logic              overrun,
  input  logic              clr_flags
);
  localparam int LOG_BPB = $clog2(BINS_PER_BAND);
  localparam int ACC_W   = 24 + LOG_BPB;
  localparam int IDX_W   = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int NBINS   = NUM_BANDS * BINS_PER_BAND;

  typedef enum logic {WAIT_SYNC, COLLECT}    col_st_t;
  typedef enum logic {OUT_IDLE, OUT_STREAM}  out_st_t;

  typedef struct packed {
    logic        vld;
    logic [6:0]  idx;
    logic [23:0] mag;
  } bin_req_t;

  bin_req_t                   req;
  col_st_t                    col_st;
  out_st_t                    out_st;
  logic [6:0]                 exp_idx;
  logic [IDX_W-1:0]           ptr;
  logic                       valid_q;
  logic [NUM_BANDS-1:0][23:0] level;
  logic [NUM_BANDS-1:0]       lane_add;
  logic hit, miss, frame_done, acc_clr, in_range, lvl_upd;

  assign req = '{vld: mag_valid, idx: freq_index, mag: freq_mag};

  assign hit        = (col_st == COLLECT) && req.vld && (req.idx == exp_idx);
  assign miss       = (col_st == COLLECT) && req.vld && (req.idx != exp_idx);
  assign frame_done = hit && (req.idx == 7'd127);
  // exp_idx is never 0 while collecting, so any valid bin 0 (re)starts a frame.
  assign acc_clr    = req.vld && (req.idx == 7'd0);
  assign in_range   = (req.idx != 7'd0) && ({1'b0, req.idx} < 8'(NBINS));
  assign lvl_upd    = frame_done && (out_st == OUT_IDLE);

  for (genvar b = 0; b < NUM_BANDS; b++) begin : g_lane
    assign lane_add[b] = hit && in_range && (7'(req.idx >> LOG_BPB) == 7'(b));

    spectrum_bands_lane #(
      .ACC_W(ACC_W), .LOG_BPB(LOG_BPB), .DECAY_SHIFT(DECAY_SHIFT)
    ) u_lane (
      .clk_100mhz (clk_100mhz),
      .rst_n      (rst_n),
      .acc_clr    (acc_clr),
      .acc_add    (lane_add[b]),
      .mag        (req.mag),
      .lvl_upd    (lvl_upd),
      .level      (level[b])
    );
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      col_st  <= WAIT_SYNC;
      exp_idx <= '0;
    end else begin
      case (col_st)
        WAIT_SYNC: if (acc_clr) begin
          col_st  <= COLLECT;
          exp_idx <= 7'd1;
        end
        COLLECT: begin
          if (hit) begin
            exp_idx <= exp_idx + 7'd1;
            if (frame_done) col_st <= WAIT_SYNC;
          end else if (miss) begin
            if (req.idx == 7'd0) exp_idx <= 7'd1;
            else                 col_st  <= WAIT_SYNC;
          end
        end
        default: col_st <= WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      out_st  <= OUT_IDLE;
      ptr     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (out_st)
        OUT_IDLE: if (frame_done) begin
          out_st  <= OUT_STREAM;
          ptr     <= '0;
          valid_q <= 1'b1;
        end
        OUT_STREAM: if (bnd.band_ready) begin
          if (ptr == IDX_W'(NUM_BANDS - 1)) begin
            out_st  <= OUT_IDLE;
            ptr     <= '0;
            valid_q <= 1'b0;
          end else begin
            ptr <= ptr + IDX_W'(1);
          end
        end
        default: out_st <= OUT_IDLE;
      endcase
    end
  end

  // A new error in the same cycle as clr_flags keeps the flag set.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (miss)           sync_err <= 1'b1;
      else if (clr_flags) sync_err <= 1'b0;
      if (frame_done && (out_st == OUT_STREAM)) overrun <= 1'b1;
      else if (clr_flags)                       overrun <= 1'b0;
    end
  end

  // Levels only change in OUT_IDLE, so the mux is stable for a whole stream.
  assign bnd.band_valid = valid_q;
  assign bnd.band_index = ptr;
  assign bnd.band_level = valid_q ? level[ptr] : 24'd0;
endmodule

// File: tb/tb_spectrum_bands.sv
// Bench for spectrum_bands: frame table plus hand-built backpressure,
// sync-loss and reset sequences, with a band scoreboard.
module tb_spectrum_bands;
  localparam int NB = 8;

  logic        clk_100mhz = 1'b0;
  logic        rst_n      = 1'b0;
  logic [23:0] freq_mag   = '0;
  logic [6:0]  freq_index = '0;
  logic        mag_valid  = 1'b0;
  logic        clr_flags  = 1'b0;
  logic        sync_err, overrun;

  spectrum_bands_if #(.IDX_W(3)) bnd ();

  spectrum_bands #(.NUM_BANDS(NB), .BINS_PER_BAND(8), .DECAY_SHIFT(4)) dut (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .freq_mag   (freq_mag),
    .freq_index (freq_index),
    .mag_valid  (mag_valid),
    .bnd        (bnd),
    .sync_err   (sync_err),
    .overrun    (overrun),
    .clr_flags  (clr_flags)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  typedef logic [23:0] lvls_t [NB];
  typedef struct { logic [2:0] idx; logic [23:0] lvl; } band_exp_t;
  typedef struct { bit rst; int kind; logic [23:0] val; lvls_t exp; } vec_t;

  band_exp_t sb[$];
  vec_t      tbl[6];
  int        tests = 0;
  int        fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic lvls_t mk(input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] er);
    lvls_t r;
    for (int b = 0; b < NB; b++) r[b] = er;
    r[0] = e0;
    r[1] = e1;
    return r;
  endfunction

  // kind 0: flat, 1: bins 8..15 only, 2: bin 8 and 64..127 full-scale, 3: silence
  function automatic logic [23:0] mag_of(input int kind, input logic [23:0] val, input int i);
    case (kind)
      0:       return val;
      1:       return (i >= 8 && i < 16) ? val : 24'd0;
      2:       return (i == 8 || i >= 64) ? 24'hFFFFFF : 24'd0;
      default: return 24'd0;
    endcase
  endfunction

  task automatic push_exp(input lvls_t e);
    band_exp_t x;
    for (int b = 0; b < NB; b++) begin
      x.idx = 3'(b);
      x.lvl = e[b];
      sb.push_back(x);
    end
  endtask

  task automatic send_bins(input int kind, input logic [23:0] val, input int first,
                           input int last, input int rdy_at);
    for (int i = first; i <= last; i++) begin
      @(posedge clk_100mhz); #1;
      if (i == rdy_at) bnd.band_ready = 1'b1;
      mag_valid  = 1'b1;
      freq_index = 7'(i);
      freq_mag   = mag_of(kind, val, i);
    end
    @(posedge clk_100mhz); #1;
    mag_valid  = 1'b0;
    freq_index = '0;
    freq_mag   = '0;
  endtask

  task automatic do_reset();
    @(posedge clk_100mhz); #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk_100mhz); #1;
    rst_n = 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge clk_100mhz); #1 clr_flags = 1'b1;
    @(posedge clk_100mhz); #1 clr_flags = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || bnd.band_valid === 1'b1) && n < 400) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk({name, "_left"}, 32'(sb.size()), 32'd0);
    chk({name, "_vld"}, 32'(bnd.band_valid), 32'd0);
  endtask

  task automatic set_vec(input int i, input bit r, input int k, input logic [23:0] v, input lvls_t e);
    tbl[i].rst  = r;
    tbl[i].kind = k;
    tbl[i].val  = v;
    tbl[i].exp  = e;
  endtask

  // Scoreboard: every accepted band must match the oldest expectation.
  always @(negedge clk_100mhz) begin
    band_exp_t e;
    if (rst_n && bnd.band_valid === 1'b1 && bnd.band_ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_band: got index %0d, want no band", bnd.band_index);
      end else begin
        e = sb.pop_front();
        chk("band_index", 32'(bnd.band_index), 32'(e.idx));
        chk("band_level", 32'(bnd.band_level), 32'(e.lvl));
      end
    end
  end

  initial begin
    int  n;
    bit  ok;
    bnd.band_ready = 1'b1;

    #12;
    chk("rst_valid", 32'(bnd.band_valid), 0);
    chk("rst_index", 32'(bnd.band_index), 0);
    chk("rst_level", 32'(bnd.band_level), 0);
    chk("rst_sync_err", 32'(sync_err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    @(posedge clk_100mhz); #1 rst_n = 1'b1;

    set_vec(0, 1'b1, 0, 24'd100,  mk(24'd87, 24'd100,      24'd100));
    set_vec(1, 1'b1, 1, 24'd4096, mk(24'd0,  24'd4096,     24'd0));
    set_vec(2, 1'b0, 3, 24'd0,    mk(24'd0,  24'd3840,     24'd0));
    set_vec(3, 1'b0, 3, 24'd0,    mk(24'd0,  24'd3600,     24'd0));
    set_vec(4, 1'b1, 2, 24'd0,    mk(24'd0,  24'h1FFFFF,   24'd0));
    set_vec(5, 1'b0, 0, 24'd100,  mk(24'd87, 24'h1E0000,   24'd100));

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].rst) do_reset();
      push_exp(tbl[i].exp);
      send_bins(tbl[i].kind, tbl[i].val, 0, 127, -1);
      @(negedge clk_100mhz);
      chk("lat_valid", 32'(bnd.band_valid), 1);
      chk("lat_index", 32'(bnd.band_index), 0);
      n = 0;
      while (bnd.band_valid === 1'b1 && n < 20) begin
        n++;
        @(negedge clk_100mhz);
      end
      chk("stream_len", 32'(n), 32'd8);
      drain("tbl");
    end

    // Backpressure, then a frame arriving mid-stream is dropped.
    do_reset();
    bnd.band_ready = 1'b0;
    push_exp(mk(24'd87, 24'd100, 24'd100));
    send_bins(0, 24'd100, 0, 127, -1);
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_100mhz);
      if (!(bnd.band_valid === 1'b1 && bnd.band_index === 3'd0 && bnd.band_level === 24'd87)) ok = 1'b0;
    end
    chk("bp_hold_stable", 32'(ok), 1);
    send_bins(0, 24'd500, 0, 127, -1);
    @(negedge clk_100mhz);
    chk("bp_overrun", 32'(overrun), 1);
    chk("bp_still_idx0", 32'(bnd.band_index), 0);
    @(posedge clk_100mhz); #1 bnd.band_ready = 1'b1;
    drain("bp_frame1");
    push_exp(mk(24'd175, 24'd200, 24'd200));
    send_bins(0, 24'd200, 0, 127, -1);
    drain("bp_next");
    chk("bp_overrun_sticky", 32'(overrun), 1);
    pulse_clr();
    @(negedge clk_100mhz);
    chk("bp_overrun_clr", 32'(overrun), 0);

    // Last band accepted on the same edge as the next frame's final bin.
    bnd.band_ready = 1'b0;
    push_exp(mk(24'd262, 24'd300, 24'd300));
    send_bins(0, 24'd300, 0, 127, -1);
    send_bins(0, 24'd999, 0, 127, 120);
    @(negedge clk_100mhz);
    chk("edge_drop_valid", 32'(bnd.band_valid), 0);
    chk("edge_drop_overrun", 32'(overrun), 1);
    chk("edge_drop_left", 32'(sb.size()), 0);

    // Sync loss.
    do_reset();
    send_bins(0, 24'd100, 0, 9, -1);
    send_bins(0, 24'd100, 12, 12, -1);
    @(negedge clk_100mhz);
    chk("sync_err_set", 32'(sync_err), 1);
    chk("sync_no_valid", 32'(bnd.band_valid), 0);
    push_exp(mk(24'd87, 24'd100, 24'd100));
    send_bins(0, 24'd100, 0, 127, -1);
    drain("sync_recover");
    chk("sync_err_sticky", 32'(sync_err), 1);
    pulse_clr();
    @(negedge clk_100mhz);
    chk("sync_err_clr", 32'(sync_err), 0);
    push_exp(mk(24'd262, 24'd300, 24'd300));
    send_bins(0, 24'd300, 0, 40, -1);
    send_bins(0, 24'd300, 0, 127, -1);
    drain("sync_restart");
    chk("sync_err_restart", 32'(sync_err), 1);

    // Reset mid-stream.
    push_exp(mk(24'd246, 24'd282, 24'd282));
    send_bins(0, 24'd100, 0, 127, -1);
    n = 0;
    while (!(bnd.band_valid === 1'b1 && bnd.band_index === 3'd3) && n < 20) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk("rst_reach_idx3", 32'(n < 20), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bnd.band_valid), 0);
    chk("mid_rst_level", 32'(bnd.band_level), 0);
    chk("mid_rst_index", 32'(bnd.band_index), 0);
    chk("mid_rst_sync_err", 32'(sync_err), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    sb.delete();
    @(posedge clk_100mhz); #1 rst_n = 1'b1;
    send_bins(0, 24'd100, 5, 127, -1);
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_100mhz);
      if (bnd.band_valid !== 1'b0) ok = 1'b0;
    end
    chk("post_rst_partial_quiet", 32'(ok), 1);
    push_exp(mk(24'd0, 24'd4096, 24'd0));
    send_bins(1, 24'd4096, 0, 127, -1);
    drain("post_rst_frame");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spectrum_bands.md
# spectrum_bands

Consumes the per-bin magnitude stream produced by the FFT magnitude stage (`freq_mag`, `freq_index`, `valid` from the CORDIC output) and reduces each 128-bin frame to NUM_BANDS LED band levels. Each band level is the average of its bins with peak-hold and exponential decay. Completed frames are streamed to the LED driver over a valid/ready handshake. The block sits between the FFT magnitude path and the LED pattern logic. Everything runs on the 100 MHz system clock.

## Interface
- NUM_BANDS, 8: number of output bands; power of two.
- BINS_PER_BAND, 8: consecutive bins per band; power of two; NUM_BANDS*BINS_PER_BAND ≤ 128.
- DECAY_SHIFT, 4: on decay, level drops by level>>DECAY_SHIFT per frame.

Ports:
- clk_100mhz  in  1  system clock. All logic runs on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- freq_mag  in  24  bin magnitude.
- freq_index  in  7  bin number, 0..127.
- mag_valid  in  1  freq_mag/freq_index valid this cycle. There is no backpressure toward the FFT.
- band_level  out  24  current band level.
- band_index  out  log2(NUM_BANDS)  band number of band_level.
- band_valid  out  1  band_level/band_index valid.
- band_ready  in  1  downstream accepts the band this cycle.
- sync_err  out  1  sticky: an out-of-sequence bin index was seen.
- overrun  out  1  sticky: a frame was dropped because the output was still streaming.
- clr_flags  in  1  synchronous clear of sync_err and overrun.

## Operation
- Collector FSM, WAIT_SYNC / COLLECT, with a 7-bit exp_idx.
  - WAIT_SYNC: on mag_valid && freq_index==0, clear all accumulators, set exp_idx=1, go to COLLECT. Any other index is ignored.
  - COLLECT, mag_valid && freq_index==exp_idx:
    - Add freq_mag to acc[freq_index/BINS_PER_BAND] only if 1 ≤ freq_index < NUM_BANDS*BINS_PER_BAND. Bin 0 (DC) never contributes.
    - Increment exp_idx.
    - If freq_index==127, raise frame_done and return to WAIT_SYNC.
  - COLLECT, mag_valid && freq_index≠exp_idx: set sync_err and discard the partial frame.
    - If the offending index is 0, restart collection in the same cycle (clear accumulators, exp_idx=1, stay in COLLECT).
    - Otherwise go to WAIT_SYNC.
- Accumulators are 24+log2(BINS_PER_BAND) bits and cannot overflow. avg[b] = acc[b] >> log2(BINS_PER_BAND), truncated to 24 bits.
- Output FSM, OUT_IDLE / OUT_STREAM, with band counter ptr.
  - On frame_done in OUT_IDLE, update every band in parallel: level[b] ← (avg[b] ≥ level[b]) ? avg[b] : level[b] − (level[b]>>DECAY_SHIFT). Then set ptr=0 and go to OUT_STREAM.
  - On frame_done in OUT_STREAM: levels are unchanged, the frame is dropped, overrun is set, and streaming continues undisturbed.
  - OUT_STREAM: band_valid=1, band_index=ptr, band_level=level[ptr].
    - On band_valid && band_ready: increment ptr. After ptr==NUM_BANDS−1 is accepted, go to OUT_IDLE.
- Valid/ready rules:
  - band_valid does not depend combinationally on band_ready.
  - band_index and band_level are stable while band_valid && !band_ready.
  - band_valid deasserts only after the last band is accepted.
- Flags:
  - clr_flags clears both flags.
  - If clr_flags coincides with a new error, the set wins.

## Timing
- Reset, asynchronous, takes effect immediately, all outputs 0:
  - band_valid=0, band_index=0, band_level=0, sync_err=0, overrun=0.
  - All level registers and accumulators are 0.
  - FSMs go to WAIT_SYNC and OUT_IDLE.
  - Reset mid-frame or mid-stream abandons the frame. No band is emitted until a full new frame arrives.
- Accepts one bin per cycle. The FFT outputs 128-cycle bursts, about every 5.3 ms.
- Latency: mag_valid with index 127 on cycle N → level registers updated and band_valid=1 with band_index=0 on cycle N+1.
- With band_ready held at 1, a frame streams in exactly NUM_BANDS consecutive cycles, N+1..N+NUM_BANDS.
- A frame_done on the same cycle the last band is accepted counts as OUT_STREAM, so it is dropped and overrun is set.
- The frame_done bin itself is accumulated before avg is computed.

## Test plan
- Frame 0..127, all freq_mag=100, band_ready=1 → band 0 = 87 (700>>3), bands 1..7 = 100, band_valid high on cycles N+1..N+8 with band_index 0..7.
- Decay sequence (default parameters):
  - Frame A: bins 8..15 = 4096, all other bins 0 → band 1 = 4096.
  - Two following all-zero frames → band 1 = 3840, then 3600.
  - Other bands stay 0.
- Range and width: bin 8 = 0xFFFFFF, bins 64..127 = 0xFFFFFF, all else 0 → band 1 = 0x1FFFFF, all other bands 0.
- Backpressure:
  - Hold band_ready=0 for 20 cycles after band_valid rises → band_index=0 and band_level held stable.
  - Deliver a second full frame while still streaming → overrun=1, remaining streamed values are from frame 1.
  - The next frame after the stream completes updates normally.
- Sync loss:
  - Indices 0..9 then 12 → sync_err=1, no band_valid.
  - Next complete frame 0..127 → normal output, sync_err stays 1 until clr_flags.
  - Also: 0..40 then 0..127 → single clean frame output, sync_err=1.
- Reset: drop rst_n while band_index=3 is presented → band_valid, band_level and flags go to 0 immediately. After release, only a full new frame produces output, with levels computed from a zero history.
